jtdd2_dwnld: RTL
================

// Module: jtdd2_dwnld
// PURPOSE
//  ROM download sequencer for the DD2 core, upstream of the game top's SDRAM and PROM consumers.
//  Converts the ioctl byte stream into SDRAM byte writes (prog_*), with an sdram_ack handshake.
//  Re-interleaves the scroll halves (ZW/XY) and object halves (WZ/XY) into 16-bit words at SCR_SDRAM/OBJ_SDRAM.
//  Diverts the PROM tail to a BRAM write strobe; a 2-entry FIFO absorbs ioctl bursts during SDRAM waits.
// PARAMETERS
//  SCRZW_ADDR 22'h90000  byte offset of first scroll half in download
//  OBJWZ_ADDR 22'hD0000  byte offset of first object half
//  PROM_ADDR  22'h190000 byte offset of PROM region (to end of download)
//  SCR_SDRAM  22'h60000  word address of interleaved scroll data
//  OBJ_SDRAM  22'h80000  word address of interleaved object data
//  SCR_HALF   22'h20000  bytes per scroll half; OBJ_HALF 22'h60000 bytes per object half
// PORTS
//  clk         in   1   system clock (48 MHz)
//  rst_n       in   1   asynchronous reset, active low
//  downloading in   1   download window active
//  ioctl_addr  in   25  download byte address
//  ioctl_data  in   8   download byte
//  ioctl_wr    in   1   one-cycle byte strobe
//  sdram_ack   in   1   SDRAM accepted current write
//  prog_addr   out  22  SDRAM word address / PROM index in [7:0]
//  prog_data   out  8   byte to write
//  prog_mask   out  2   byte-lane mask, 1 = lane NOT written
//  prog_we     out  1   SDRAM write request, held until ack
//  prom_we     out  1   one-cycle PROM BRAM write strobe
//  dwnld_busy  out  1   downloading OR FIFO/write pending
//  ovf         out  1   sticky: byte dropped on FIFO full
// BEHAVIOUR
//  Reset (rst_n=0, async): prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0, prom_we=0, ovf=0, FIFO empty, state IDLE.
//  Decode on ioctl_wr (offset o=ioctl_addr):
//   o<SCRZW_ADDR, or SCRZW_ADDR+2*SCR_HALF<=o<OBJWZ_ADDR: addr=o>>1, lane=o[0].
//   SCR: r=o-SCRZW_ADDR; h=(r>=SCR_HALF); addr=SCR_SDRAM+(r-h*SCR_HALF); lane=h.
//   OBJ: r=o-OBJWZ_ADDR; h=(r>=OBJ_HALF); addr=OBJ_SDRAM+(r-h*OBJ_HALF); lane=h.
//   o>=PROM_ADDR: PROM entry, index=o-PROM_ADDR (low 8 bits kept).
//   lane 0 -> mask 2'b10; lane 1 -> mask 2'b01.
//  Decoded entry {kind,addr,data,mask} is pushed into 2-deep FIFO the cycle after ioctl_wr; push ignored if downloading=0.
//  FIFO full on push: byte dropped, ovf set (sticky until reset). Push+pop same cycle on full FIFO: accepted.
//  FSM: IDLE -> (FIFO non-empty, SDRAM entry) WAIT_ACK: prog_* loaded from head, prog_we=1 next cycle.
//   WAIT_ACK: hold prog_addr/data/mask/we stable; on sdram_ack: pop, prog_we=0, go IDLE (min 1 idle cycle between writes).
//   IDLE + PROM head: prog_addr[7:0]=index, prog_data=byte, prom_we=1 for exactly 1 cycle, pop; no SDRAM request.
//  Latency: ioctl_wr -> prog_we high = 2 cycles with empty FIFO; ack -> next prog_we = 2 cycles.
//  sdram_ack while prog_we=0: ignored. downloading falling mid-write: current write completes, FIFO drains.
//  dwnld_busy = downloading | FIFO non-empty | state!=IDLE; drops 1 cycle after last ack/prom_we.
//  Address arithmetic in 25 bits, truncated to 22 on output; regions are mutually exclusive, PROM has priority at boundary.
// TESTING
//  Byte 8'h5A at o=0x00001, ack after 3 cycles -> prog_addr=0x0, mask=2'b01, data=5A, we high 2 cycles after wr until ack.
//  o=0x90004 and o=0xB0004 -> both prog_addr=0x60004; masks 2'b10 then 2'b01.
//  o=0xD0010 and o=0x130010 -> both prog_addr=0x80010; masks 2'b10 then 2'b01.
//  o=0x190023, data 4'h7 -> prom_we one cycle, prog_addr[7:0]=0x23, prog_we stays 0.
//  3 wr strobes back-to-back, ack withheld 20 cycles -> 2 writes emitted in order, third dropped, ovf=1.
//  rst_n low during WAIT_ACK -> prog_we=0, mask=2'b11, busy=downloading, FIFO empty immediately.

Source files
------------

// File: rtl/jtdd2_dwnld_if.sv
// Download-side bus of the DD2 ROM sequencer:
// ioctl byte stream in, SDRAM/PROM write requests out.
interface jtdd2_dwnld_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic        dwnld_busy;
  logic        ovf;

  modport master (
    output downloading, ioctl_addr, ioctl_data,
    output ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask,
    input  prog_we, prom_we, dwnld_busy, ovf
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data,
    input  ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask,
    output prog_we, prom_we, dwnld_busy, ovf
  );
endinterface

// File: rtl/jtdd2_dwnld.sv
// DD2 ROM download sequencer: decodes ioctl bytes,
// re-interleaves gfx halves, queues SDRAM / PROM writes.
module jtdd2_dwnld #(
  parameter logic [24:0] SCRZW_ADDR = 25'h90000,
  parameter logic [24:0] OBJWZ_ADDR = 25'hD0000,
  parameter logic [24:0] PROM_ADDR  = 25'h190000,
  parameter logic [24:0] SCR_SDRAM  = 25'h60000,
  parameter logic [24:0] OBJ_SDRAM  = 25'h80000,
  parameter logic [24:0] SCR_HALF   = 25'h20000,
  parameter logic [24:0] OBJ_HALF   = 25'h60000
) (
  input  logic         clk,
  input  logic         rst_n,
  jtdd2_dwnld_if.slave dl_if
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  typedef struct packed {
    logic        prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } ent_t;

  localparam logic [24:0] SCR_END = SCRZW_ADDR + (SCR_HALF << 1);
  localparam logic [24:0] OBJ_END = OBJWZ_ADDR + (OBJ_HALF << 1);

  state_t      state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic        prom_q, prom_d;
  logic        ovf_q, ovf_d;
  ent_t        mem_q [2];
  logic        rd_q, wr_q;
  logic [1:0]  cnt_q, cnt_d;

  logic [24:0] o, r;
  logic [21:0] a;
  logic        is_prom, is_obj, is_scr, h;
  logic        push_req, push, pop;
  ent_t        in_e, head;

  // Region decode; PROM wins at its boundary
  always_comb begin
    o       = dl_if.ioctl_addr;
    is_prom = o >= PROM_ADDR;
    is_obj  = !is_prom && o >= OBJWZ_ADDR
              && o < OBJ_END;
    is_scr  = !is_prom && !is_obj
              && o >= SCRZW_ADDR && o < SCR_END;
    r       = '0;
    h       = 1'b0;
    a       = '0;
    in_e    = '0;
    unique case (1'b1)
      is_prom: begin
        r    = o - PROM_ADDR;
        a    = {14'd0, r[7:0]};
      end
      is_obj: begin
        r    = o - OBJWZ_ADDR;
        h    = r >= OBJ_HALF;
        a    = 22'(OBJ_SDRAM
               + (h ? r - OBJ_HALF : r));
      end
      is_scr: begin
        r    = o - SCRZW_ADDR;
        h    = r >= SCR_HALF;
        a    = 22'(SCR_SDRAM
               + (h ? r - SCR_HALF : r));
      end
      default: begin
        a    = 22'(o >> 1);
        h    = o[0];
      end
    endcase
    in_e.prom = is_prom;
    in_e.addr = a;
    in_e.data = dl_if.ioctl_data;
    in_e.mask = is_prom ? 2'b11
              : (h ? 2'b01 : 2'b10);
  end

  assign head = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    we_d    = we_q;
    prom_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != 2'd0) begin
          addr_d = head.addr;
          data_d = head.data;
          mask_d = head.mask;
          if (head.prom) begin
            prom_d = 1'b1;
            pop    = 1'b1;
          end else begin
            we_d    = 1'b1;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (dl_if.sdram_ack) begin
          pop     = 1'b1;
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    push_req = dl_if.ioctl_wr & dl_if.downloading;
    // A full FIFO still accepts when the head leaves this cycle
    push  = push_req & ((cnt_q != 2'd2) | pop);
    ovf_d = ovf_q | (push_req & ~push);
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= 2'b11;
      we_q    <= 1'b0;
      prom_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      prom_q  <= prom_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_q ^ pop;
      wr_q    <= wr_q ^ push;
      cnt_q   <= cnt_d;
      if (push) mem_q[wr_q] <= in_e;
    end
  end

  assign dl_if.prog_addr  = addr_q;
  assign dl_if.prog_data  = data_q;
  assign dl_if.prog_mask  = mask_q;
  assign dl_if.prog_we    = we_q;
  assign dl_if.prom_we    = prom_q;
  assign dl_if.ovf        = ovf_q;
  assign dl_if.dwnld_busy = dl_if.downloading
                          | (cnt_q != 2'd0)
                          | (state_q != IDLE);

endmodule
